pid_pwm_driver: RTL and testbench

PID_PWM_DRIVER -- requirements
Module: pid_pwm_driver

---
 rtl/pid_pwm_driver.sv | 195 +++++++++++++++++++
 tb/tb_pid_pwm_driver.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_pwm_driver.sv
// pid_pwm_driver: turns signed PID samples into a glitch-free PWM waveform.
// Each sample is clamped to [0, Period] and written to a shadow duty register.
// The shadow value moves to the active duty register only when the period
// counter wraps, so a period is never cut short or stretched.
// Optional feature macro PID_PWM_SAT_FAULT_EN: when defined, a run of SatLimit
// consecutive saturated samples trips a latched FAULT state that clr_fault
// releases. When undefined, fault is tied low and clr_fault is ignored.
module pid_pwm_driver #(
    parameter int Width    = 18,
    parameter int CntWidth = 10,
    parameter int Period   = 1000,
    parameter int SatLimit = 8
) (
    input  logic                       sclk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic signed [Width-1:0]    pid_output,
    input  logic                       clr_fault,
    output logic                       pwm_out,
    output logic [CntWidth-1:0]        duty,
    output logic                       sat_hi,
    output logic                       sat_lo,
    output logic                       period_start,
    output logic                       fault
);

    // Compare width leaves headroom so that the sample and Period can both be
    // represented as signed values without overflow.
    localparam int CmpW = ((Width > CntWidth) ? Width : CntWidth) + 2;
    localparam logic signed [CmpW-1:0] PERIOD_S = CmpW'(Period);
    localparam logic [CntWidth-1:0]    CNT_LAST = CntWidth'(Period - 1);
    localparam logic [CntWidth-1:0]    DUTY_MAX = CntWidth'(Period);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef struct packed {
        logic                hi;
        logic                lo;
        logic [CntWidth-1:0] val;
    } clamp_t;

    // Clamp a signed sample into the legal duty range and flag which side hit.
    function automatic clamp_t clamp_sample(input logic signed [Width-1:0] s);
        logic signed [CmpW-1:0] s_ext;
        clamp_t                 r;
        s_ext = CmpW'(s);
        r.hi  = 1'b0;
        r.lo  = 1'b0;
        r.val = '0;
        if (s_ext[CmpW-1]) begin
            r.lo = 1'b1;
        end else if (s_ext > PERIOD_S) begin
            r.hi  = 1'b1;
            r.val = DUTY_MAX;
        end else begin
            r.val = s_ext[CntWidth-1:0];
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth-1:0] shadow_q, shadow_d;
    logic [CntWidth-1:0] active_q, active_d;
    logic                pwm_q, pwm_d;
    logic                sat_hi_q, sat_hi_d;
    logic                sat_lo_q, sat_lo_d;
    clamp_t              sample;

    assign sample = clamp_sample(pid_output);

`ifdef PID_PWM_SAT_FAULT_EN
    localparam int SatW = $clog2(SatLimit + 1);
    logic [SatW-1:0] sat_cnt_q, sat_cnt_d;
    logic            sample_sat;
    logic            trip;
    assign sample_sat = sample.hi | sample.lo;
`else
    logic unused_clr_fault;
    assign unused_clr_fault = clr_fault;
`endif

    // Next-state, counter, duty pipeline and registered PWM decision.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        sat_hi_d = sat_hi_q;
        sat_lo_d = sat_lo_q;
        pwm_d    = 1'b0;
`ifdef PID_PWM_SAT_FAULT_EN
        sat_cnt_d = sat_cnt_q;
        trip      = 1'b0;
        if (enable && (state_q != FAULT)) begin
            sat_cnt_d = sample_sat ? (sat_cnt_q + 1'b1) : '0;
            trip      = sample_sat && (sat_cnt_d == SatW'(SatLimit));
        end
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    shadow_d = sample.val;
                    active_d = sample.val;
                    sat_hi_d = sample.hi;
                    sat_lo_d = sample.lo;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Decision uses the pre-wrap active duty; the new one governs
                // the period that starts at cnt==0.
                pwm_d = (cnt_q < active_q);
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    active_d = shadow_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (enable) begin
                    shadow_d = sample.val;
                    sat_hi_d = sample.hi;
                    sat_lo_d = sample.lo;
                end
            end
            FAULT: begin
                cnt_d = '0;
`ifdef PID_PWM_SAT_FAULT_EN
                if (clr_fault) begin
                    state_d   = IDLE;
                    sat_cnt_d = '0;
                    shadow_d  = '0;
                    active_d  = '0;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
`ifdef PID_PWM_SAT_FAULT_EN
        // A trip overrides everything else, including a same-edge clr_fault.
        if (trip) begin
            state_d = FAULT;
            cnt_d   = '0;
            pwm_d   = 1'b0;
        end
`endif
    end

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pwm_q     <= 1'b0;
            sat_hi_q  <= 1'b0;
            sat_lo_q  <= 1'b0;
`ifdef PID_PWM_SAT_FAULT_EN
            sat_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pwm_q     <= pwm_d;
            sat_hi_q  <= sat_hi_d;
            sat_lo_q  <= sat_lo_d;
`ifdef PID_PWM_SAT_FAULT_EN
            sat_cnt_q <= sat_cnt_d;
`endif
        end
    end

    assign pwm_out      = pwm_q;
    assign duty         = active_q;
    assign sat_hi       = sat_hi_q;
    assign sat_lo       = sat_lo_q;
    assign period_start = (state_q == RUN) && (cnt_q == '0);
`ifdef PID_PWM_SAT_FAULT_EN
    assign fault        = (state_q == FAULT);
`else
    assign fault        = 1'b0;
`endif

endmodule

// File: tb/tb_pid_pwm_driver.sv
// Self-checking bench for pid_pwm_driver: directed scenarios followed by a
// randomized phase, all checked every cycle against a behavioural model.
module tb_pid_pwm_driver;

    localparam int Width    = 18;
    localparam int CntWidth = 10;
    localparam int Period   = 1000;
    localparam int SatLimit = 8;
`ifdef PID_PWM_SAT_FAULT_EN
    localparam bit FaultEn = 1'b1;
`else
    localparam bit FaultEn = 1'b0;
`endif

    logic                    sclk = 1'b0;
    logic                    rst = 1'b1;
    logic                    enable = 1'b0;
    logic signed [Width-1:0] pid_output = '0;
    logic                    clr_fault = 1'b0;
    logic                    pwm_out;
    logic [CntWidth-1:0]     duty;
    logic                    sat_hi, sat_lo, period_start, fault;

    pid_pwm_driver #(
        .Width(Width), .CntWidth(CntWidth), .Period(Period), .SatLimit(SatLimit)
    ) dut (
        .sclk(sclk), .rst(rst), .enable(enable), .pid_output(pid_output),
        .clr_fault(clr_fault), .pwm_out(pwm_out), .duty(duty), .sat_hi(sat_hi),
        .sat_lo(sat_lo), .period_start(period_start), .fault(fault)
    );

    always #5 sclk = ~sclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=idle, 1=run, 2=fault; pos = position in period.
    typedef struct {
        int mode;
        int pos;
        int shadow;
        int active;
        int sat_run;
        bit pwm;
        bit hi;
        bit lo;
    } model_t;

    model_t m = '{default: 0};

    function automatic model_t model_next(model_t c, bit en, int s, bit clr);
        model_t n = c;
        int     v = s;
        bit     h = 1'b0;
        bit     l = 1'b0;
        bit     trip = 1'b0;
        if (s < 0) begin
            v = 0; l = 1'b1;
        end else if (s > Period) begin
            v = Period; h = 1'b1;
        end
        n.pwm = 1'b0;
        if (en && c.mode != 2) begin
            n.hi = h;
            n.lo = l;
            n.sat_run = (h || l) ? c.sat_run + 1 : 0;
            trip = FaultEn && (n.sat_run >= SatLimit);
        end
        if (c.mode == 0) begin
            n.pos = 0;
            if (en) begin
                n.shadow = v; n.active = v; n.mode = 1;
            end
        end else if (c.mode == 1) begin
            n.pwm = (c.pos < c.active);
            n.pos = (c.pos + 1) % Period;
            if (n.pos == 0) n.active = c.shadow;
            if (en) n.shadow = v;
        end else begin
            n.pos = 0;
            if (clr) begin
                n.mode = 0; n.sat_run = 0; n.shadow = 0; n.active = 0;
            end
        end
        if (trip) begin
            n.mode = 2; n.pos = 0; n.pwm = 1'b0;
        end
        return n;
    endfunction

    // Model advances on the same edges as the DUT.
    always @(posedge sclk or posedge rst) begin
        if (rst) m <= '{default: 0};
        else     m <= model_next(m, enable, int'(pid_output), clr_fault);
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge sclk) begin
        check_eq("cyc_pwm_out", pwm_out, m.pwm);
        check_eq("cyc_duty", duty, m.active);
        check_eq("cyc_period_start", period_start, (m.mode == 1 && m.pos == 0));
        check_eq("cyc_sat_hi", sat_hi, m.hi);
        check_eq("cyc_sat_lo", sat_lo, m.lo);
        check_eq("cyc_fault", fault, (m.mode == 2));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic pulse(input int val);
        enable = 1'b1;
        pid_output = Width'(val);
        @(negedge sclk);
        enable = 1'b0;
    endtask

    task automatic wait_ps();
        int k = 0;
        while (period_start !== 1'b1 && k < 2 * Period) begin
            @(negedge sclk);
            k++;
        end
        check_eq("wait_period_start_bound", (k < 2 * Period), 1);
    endtask

    task automatic wait_pos(input int target);
        int k = 0;
        while (!(m.mode == 1 && m.pos == target) && k < 2 * Period) begin
            @(negedge sclk);
            k++;
        end
        check_eq("wait_pos_bound", (k < 2 * Period), 1);
    endtask

    // Starting at a period_start cycle, count high cycles over one period.
    task automatic measure(input string tag, input int exp_high);
        int hi_cnt = 0;
        int ps_cnt = 0;
        for (int i = 0; i < Period; i++) begin
            if (pwm_out === 1'b1) hi_cnt++;
            if (period_start === 1'b1) ps_cnt++;
            @(negedge sclk);
        end
        check_eq(tag, hi_cnt, exp_high);
        check_eq({tag, "_period_starts"}, ps_cnt, 1);
    endtask

    initial begin
        @(negedge sclk);
        tick(2);
        check_eq("rst_pwm", pwm_out, 0);
        check_eq("rst_duty", duty, 0);
        check_eq("rst_ps", period_start, 0);
        check_eq("rst_fault", fault, 0);
        check_eq("rst_sat", {sat_hi, sat_lo}, 0);
        rst = 1'b0;
        tick(5);
        check_eq("idle_ps", period_start, 0);
        check_eq("idle_pwm", pwm_out, 0);

        // First sample starts the PWM.
        pulse(250);
        check_eq("start_duty_250", duty, 250);
        wait_ps();
        measure("high_250", 250);

        // Mid-period update waits for the wrap.
        wait_pos(400);
        pulse(600);
        check_eq("keep_250", duty, 250);
        wait_ps();
        check_eq("duty_600", duty, 600);
        measure("high_600", 600);

        // Clamping at both ends.
        pulse(-5);
        check_eq("neg_sat_lo", sat_lo, 1);
        check_eq("neg_sat_hi", sat_hi, 0);
        wait_ps();
        check_eq("duty_0", duty, 0);
        measure("high_0", 0);
        pulse(5000);
        check_eq("big_sat_hi", sat_hi, 1);
        check_eq("big_sat_lo", sat_lo, 0);
        wait_ps();
        tick(1);
        wait_ps();
        check_eq("duty_max", duty, Period);
        measure("high_max", Period);

        // Seven saturated, one clean, seven saturated: no trip.
        pulse(300);
        for (int i = 0; i < 7; i++) begin
            pulse((i % 2) ? -100 : 2000);
            tick(3);
        end
        pulse(500);
        tick(3);
        for (int i = 0; i < 7; i++) begin
            pulse(2000);
            tick(3);
        end
        check_eq("no_trip_fault", fault, 0);
        pulse(300);

        // Enable coincident with the wrap edge.
        wait_ps();
        wait_pos(500);
        pulse(450);
        wait_pos(Period - 1);
        pulse(700);
        check_eq("wrap_old_shadow", duty, 450);
        wait_pos(Period - 1);
        tick(1);
        check_eq("wrap_new_next", duty, 700);

        // Asynchronous reset in the high phase.
        wait_pos(10);
        check_eq("pre_rst_high", pwm_out, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_pwm", pwm_out, 0);
        check_eq("async_rst_duty", duty, 0);
        @(negedge sclk);
        tick(2);
        rst = 1'b0;
        tick(5);
        check_eq("post_rst_idle_ps", period_start, 0);
        pulse(400);
        wait_ps();
        measure("high_400", 400);

        // Eight saturated samples in a row.
        for (int i = 0; i < SatLimit; i++) begin
            pulse(2000);
            if (i < SatLimit - 1) tick(2);
        end
        check_eq("trip_fault", fault, FaultEn);
        check_eq("trip_pwm", pwm_out, m.pwm);
        tick(5);
        check_eq("trip_fault_held", fault, FaultEn);
        clr_fault = 1'b1;
        @(negedge sclk);
        clr_fault = 1'b0;
        check_eq("clr_fault", fault, 0);
        pulse(100);
        wait_ps();
        tick(1);
        wait_ps();
        check_eq("duty_100", duty, 100);
        measure("high_100", 100);

        // clr_fault coincident with the tripping sample.
        for (int i = 0; i < SatLimit - 1; i++) begin
            pulse(-50);
            tick(2);
        end
        clr_fault = 1'b1;
        pulse(3000);
        clr_fault = 1'b0;
        check_eq("trip_with_clr", fault, FaultEn);
        clr_fault = 1'b1;
        @(negedge sclk);
        clr_fault = 1'b0;

        // Randomized phase.
        for (int i = 0; i < 15000; i++) begin
            @(negedge sclk);
            enable     = ($urandom_range(0, 39) == 0);
            pid_output = Width'(int'($urandom_range(0, 1600)) - 300);
            clr_fault  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3999) == 0) begin
                #2 rst = 1'b1;
                @(negedge sclk);
                #2 rst = 1'b0;
            end
        end
        enable = 1'b0;
        clr_fault = 1'b0;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
